add_seq_16: RTL and testbench

- Multi-precision add/subtract sequencer built around one shared 16-bit ripple adder (adder_16).
- Accepts a WORDS×16-bit operand pair with a valid/ready handshake.
- Feeds the operands to the adder one 16-bit word per cycle, LSW first, and chains the carry through a register.
- Returns the full-width result with carry, overflow and zero flags. Sits between the ALU front end and the 16-bit adder datapath.

---
 rtl/add_seq_16_pkg.sv | 12 +
 rtl/add_seq_16_adder.sv | 21 ++
 rtl/add_seq_16.sv | 122 ++++++++++++
 tb/tb_add_seq_16.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/add_seq_16_pkg.sv
// Shared definitions for the multi-precision add/subtract sequencer.
package add_seq_16_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/add_seq_16_adder.sv
// 16-bit ripple adder with carry in/out; the single shared datapath adder.
module adder_16
  import add_seq_16_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              c_in,
  output logic [WORD_W-1:0] sum,
  output logic              c_out
);

  logic [WORD_W:0] full;

  // Carry-chained word add; the extra top bit is the carry out.
  always_comb begin
    full  = {1'b0, a} + {1'b0, b} + (WORD_W + 1)'(c_in);
    sum   = full[WORD_W-1:0];
    c_out = full[WORD_W];
  end

endmodule

// File: rtl/add_seq_16.sv
// Multi-precision add/subtract sequencer: walks WORDS 16-bit words through one
// shared adder, LSW first, carrying between words through a register.
module add_seq_16
  import add_seq_16_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_sub,
  input  logic [16*WORDS-1:0]   req_a,
  input  logic [16*WORDS-1:0]   req_b,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [16*WORDS-1:0]   resp_sum,
  output logic                  resp_carry,
  output logic                  resp_ovf,
  output logic                  resp_zero
);

  localparam int W     = WORD_W * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic               carry_q;
  logic [W-1:0]       a_q;
  logic [W-1:0]       b_q;
  logic [W-1:0]       sum_q;
  logic               carry_f;
  logic               ovf_f;
  logic               zero_f;

  logic [WORD_W-1:0]  a_word;
  logic [WORD_W-1:0]  b_word;
  logic [WORD_W-1:0]  s_word;
  logic               c_out;
  logic [W-1:0]       sum_next;
  logic               ovf_next;
  logic               zero_next;

  // Pick the current word of each latched operand for the shared adder.
  always_comb begin
    a_word = a_q[WORD_W*int'(idx) +: WORD_W];
    b_word = b_q[WORD_W*int'(idx) +: WORD_W];
  end

  adder_16 u_adder (
    .a     (a_word),
    .b     (b_word),
    .c_in  (carry_q),
    .sum   (s_word),
    .c_out (c_out)
  );

  // Sum with the current word merged in, plus the flags it would give if this is the last word.
  always_comb begin
    sum_next = sum_q;
    sum_next[WORD_W*int'(idx) +: WORD_W] = s_word;
    ovf_next  = (a_q[W-1] == b_q[W-1]) && (sum_next[W-1] != a_q[W-1]);
    zero_next = ~|sum_next;
  end

  // Sequencer: accept in IDLE, one word per cycle in RUN, hold the response in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_f <= 1'b0;
      ovf_f   <= 1'b0;
      zero_f  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            a_q     <= req_a;
            b_q     <= req_sub ? ~req_b : req_b;
            carry_q <= req_sub;
            idx     <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          sum_q   <= sum_next;
          carry_q <= c_out;
          if (idx == LAST_IDX) begin
            carry_f <= c_out;
            ovf_f   <= ovf_next;
            zero_f  <= zero_next;
            state   <= DONE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        DONE: begin
          if (resp_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake outputs are pure state decodes; result outputs come straight from registers.
  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == DONE);
    resp_sum   = sum_q;
    resp_carry = carry_f;
    resp_ovf   = ovf_f;
    resp_zero  = zero_f;
  end

endmodule

// File: tb/tb_add_seq_16.sv
// Self-checking bench for add_seq_16 (WORDS=4) against a plain-arithmetic model.
module tb_add_seq_16;

  localparam int WORDS = 4;
  localparam int W     = 16 * WORDS;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         carry;
    logic         ovf;
    logic         zero;
  } res_t;

  logic         clk;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic         req_sub;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic         resp_valid;
  logic         resp_ready;
  logic [W-1:0] resp_sum;
  logic         resp_carry;
  logic         resp_ovf;
  logic         resp_zero;

  int checks;
  int failures;

  add_seq_16 #(.WORDS(WORDS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_sub    (req_sub),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_sum   (resp_sum),
    .resp_carry (resp_carry),
    .resp_ovf   (resp_ovf),
    .resp_zero  (resp_zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: wide unsigned add/subtract, carry = no unsigned overflow/borrow,
  // ovf = signed result out of range for the operand signs.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    res_t r;
    logic [W:0] wide;
    if (!sub) begin
      wide    = {1'b0, a} + {1'b0, b};
      r.sum   = wide[W-1:0];
      r.carry = wide[W];
      r.ovf   = (a[W-1] == b[W-1]) && (r.sum[W-1] != a[W-1]);
    end else begin
      r.sum   = a - b;
      r.carry = (a >= b);
      r.ovf   = (a[W-1] != b[W-1]) && (r.sum[W-1] != a[W-1]);
    end
    r.zero = (r.sum == '0);
    return r;
  endfunction

  function automatic logic [W-1:0] rand_word();
    return {$urandom, $urandom};
  endfunction

  // Issue one request from IDLE, scramble the inputs after accept, and wait for
  // resp_valid. lat = posedges after the accept edge, or -1 on timeout.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                       output res_t got, output int lat);
    @(negedge clk);
    req_valid  = 1'b1;
    req_a      = a;
    req_b      = b;
    req_sub    = sub;
    resp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_a     = rand_word();
    req_b     = rand_word();
    req_sub   = 1'($urandom);
    lat = -1;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (resp_valid) begin
        lat = e;
        break;
      end
    end
    got = '{sum: resp_sum, carry: resp_carry, ovf: resp_ovf, zero: resp_zero};
  endtask

  task automatic release_resp();
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_sub    = 1'b0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b0;
    #12;
    checks++;
    if ({req_ready, resp_valid} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL reset_handshake: ready/valid=%b expected 10", {req_ready, resp_valid});
    end
    checks++;
    if ({resp_sum, resp_carry, resp_ovf, resp_zero} !== {W'(0), 3'b000}) begin
      failures++;
      $display("[TB] FAIL reset_outputs: sum=%h c/o/z=%b%b%b expected all 0",
               resp_sum, resp_carry, resp_ovf, resp_zero);
    end
    // A handshake while in reset must be ignored.
    req_valid = 1'b1;
    req_a     = 64'h5;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({req_ready, resp_valid} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL reset_ignores_req: ready/valid=%b expected 10", {req_ready, resp_valid});
    end
    req_valid = 1'b0;
    rst_n     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL post_reset_idle: req_ready=%b expected 1", req_ready);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] va[6];
    logic [W-1:0] vb[6];
    logic         vs[6];
    res_t         ve[6];
    res_t         got;
    int           lat;
    va[0] = 64'h0000_FFFF_FFFF_FFFF; vb[0] = 64'h1;    vs[0] = 1'b0;
    ve[0] = '{sum: 64'h0001_0000_0000_0000, carry: 1'b0, ovf: 1'b0, zero: 1'b0};
    va[1] = 64'h0;                   vb[1] = 64'h1;    vs[1] = 1'b1;
    ve[1] = '{sum: 64'hFFFF_FFFF_FFFF_FFFF, carry: 1'b0, ovf: 1'b0, zero: 1'b0};
    va[2] = 64'h7FFF_FFFF_FFFF_FFFF; vb[2] = 64'h1;    vs[2] = 1'b0;
    ve[2] = '{sum: 64'h8000_0000_0000_0000, carry: 1'b0, ovf: 1'b1, zero: 1'b0};
    va[3] = 64'h1234;                vb[3] = 64'h1234; vs[3] = 1'b1;
    ve[3] = '{sum: 64'h0, carry: 1'b1, ovf: 1'b0, zero: 1'b1};
    va[4] = 64'hFFFF_FFFF_FFFF_FFFF; vb[4] = 64'h1;    vs[4] = 1'b0;
    ve[4] = '{sum: 64'h0, carry: 1'b1, ovf: 1'b0, zero: 1'b1};
    va[5] = 64'h8000_0000_0000_0000; vb[5] = 64'h1;    vs[5] = 1'b1;
    ve[5] = '{sum: 64'h7FFF_FFFF_FFFF_FFFF, carry: 1'b1, ovf: 1'b1, zero: 1'b0};
    for (int i = 0; i < 6; i++) begin
      do_op(va[i], vb[i], vs[i], got, lat);
      // Counting the accept edge itself, WORDS=4 gives the 5th edge.
      checks++;
      if (lat != WORDS) begin
        failures++;
        $display("[TB] FAIL directed%0d_latency: edges=%0d expected %0d", i, lat, WORDS);
      end
      checks++;
      if (got !== ve[i]) begin
        failures++;
        $display("[TB] FAIL directed%0d_result: sum=%h c/o/z=%b%b%b expected sum=%h c/o/z=%b%b%b",
                 i, got.sum, got.carry, got.ovf, got.zero,
                 ve[i].sum, ve[i].carry, ve[i].ovf, ve[i].zero);
      end
      release_resp();
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    res_t         exp;
    res_t         got;
    int           lat;
    for (int i = 0; i < 12; i++) begin
      a = rand_word();
      b = rand_word();
      s = 1'($urandom);
      if (i == 3) b = a;
      if (i == 5) b = ~a;
      exp = model(a, b, s);
      do_op(a, b, s, got, lat);
      checks++;
      if (lat != WORDS || got !== exp) begin
        failures++;
        $display("[TB] FAIL random%0d: lat=%0d sum=%h c/o/z=%b%b%b expected lat=%0d sum=%h c/o/z=%b%b%b",
                 i, lat, got.sum, got.carry, got.ovf, got.zero,
                 WORDS, exp.sum, exp.carry, exp.ovf, exp.zero);
      end
      release_resp();
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] na;
    logic [W-1:0] nb;
    res_t         exp;
    res_t         exp2;
    res_t         got;
    int           lat;
    a   = rand_word();
    b   = rand_word();
    exp = model(a, b, 1'b0);
    do_op(a, b, 1'b0, got, lat);
    for (int c = 0; c < 3; c++) begin
      req_valid = 1'b1;
      req_a     = rand_word();
      req_b     = rand_word();
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({resp_valid, req_ready} !== 2'b10 ||
          {resp_sum, resp_carry, resp_ovf, resp_zero} !== {exp.sum, exp.carry, exp.ovf, exp.zero}) begin
        failures++;
        $display("[TB] FAIL backpressure_hold%0d: valid/ready=%b sum=%h expected 10 sum=%h",
                 c, {resp_valid, req_ready}, resp_sum, exp.sum);
      end
    end
    na   = rand_word();
    nb   = rand_word();
    exp2 = model(na, nb, 1'b1);
    req_a      = na;
    req_b      = nb;
    req_sub    = 1'b1;
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    checks++;
    if ({req_ready, resp_valid} !== 2'b10 || resp_sum !== exp.sum) begin
      failures++;
      $display("[TB] FAIL backpressure_release: ready/valid=%b sum=%h expected 10 sum=%h",
               {req_ready, resp_valid}, resp_sum, exp.sum);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_a     = rand_word();
    checks++;
    if (req_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL backpressure_accept: req_ready=%b expected 0", req_ready);
    end
    lat = -1;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (resp_valid) begin
        lat = e;
        break;
      end
    end
    checks++;
    if (lat != WORDS || resp_sum !== exp2.sum || resp_carry !== exp2.carry ||
        resp_ovf !== exp2.ovf || resp_zero !== exp2.zero) begin
      failures++;
      $display("[TB] FAIL backpressure_next: lat=%0d sum=%h c/o/z=%b%b%b expected lat=%0d sum=%h c/o/z=%b%b%b",
               lat, resp_sum, resp_carry, resp_ovf, resp_zero,
               WORDS, exp2.sum, exp2.carry, exp2.ovf, exp2.zero);
    end
    release_resp();
  endtask

  task automatic test_reset_mid_run();
    res_t got;
    int   lat;
    @(negedge clk);
    req_valid = 1'b1;
    req_a     = rand_word();
    req_b     = rand_word();
    req_sub   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, resp_valid} !== 2'b10 ||
        {resp_sum, resp_carry, resp_ovf, resp_zero} !== {W'(0), 3'b000}) begin
      failures++;
      $display("[TB] FAIL midrun_reset: ready/valid=%b sum=%h c/o/z=%b%b%b expected 10 and all 0",
               {req_ready, resp_valid}, resp_sum, resp_carry, resp_ovf, resp_zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_op(64'h1, 64'h1, 1'b0, got, lat);
    checks++;
    if (lat != WORDS || got !== '{sum: 64'h2, carry: 1'b0, ovf: 1'b0, zero: 1'b0}) begin
      failures++;
      $display("[TB] FAIL midrun_after: lat=%0d sum=%h c/o/z=%b%b%b expected lat=%0d sum=2 c/o/z=000",
               lat, got.sum, got.carry, got.ovf, got.zero, WORDS);
    end
    release_resp();
  endtask

  task automatic test_back_to_back();
    res_t         expq[$];
    res_t         exp;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    int           got_n;
    int           last;
    got_n      = 0;
    last       = -1;
    resp_ready = 1'b1;
    for (int cyc = 0; cyc < 200 && got_n < 5; cyc++) begin
      @(negedge clk);
      if (resp_valid) begin
        if (expq.size() > 0) exp = expq.pop_front();
        else exp = '0;
        checks++;
        if ({resp_sum, resp_carry, resp_ovf, resp_zero} !== {exp.sum, exp.carry, exp.ovf, exp.zero}) begin
          failures++;
          $display("[TB] FAIL b2b_result%0d: sum=%h c/o/z=%b%b%b expected sum=%h c/o/z=%b%b%b",
                   got_n, resp_sum, resp_carry, resp_ovf, resp_zero,
                   exp.sum, exp.carry, exp.ovf, exp.zero);
        end
        if (last >= 0) begin
          checks++;
          if (cyc - last != WORDS + 2) begin
            failures++;
            $display("[TB] FAIL b2b_spacing%0d: cycles=%0d expected %0d", got_n, cyc - last, WORDS + 2);
          end
        end
        last = cyc;
        got_n++;
      end
      if (req_ready) begin
        a = rand_word();
        b = rand_word();
        s = 1'($urandom);
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        req_sub   = s;
        expq.push_back(model(a, b, s));
      end
      @(posedge clk);
    end
    checks++;
    if (got_n < 5) begin
      failures++;
      $display("[TB] FAIL b2b_timeout: responses=%0d expected 5", got_n);
    end
    @(negedge clk);
    req_valid  = 1'b0;
    resp_ready = 1'b0;
    rst_n      = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
